// File: rtl/systolic_pkg.sv
// Shared defaults and FSM state type for the output-stationary systolic array.
package systolic_pkg;

  localparam int DIM_DEFAULT     = 8;
  localparam int BITS_AB_DEFAULT = 8;
  localparam int BITS_C_DEFAULT  = 16;

  // Pass sequencer: IDLE waits for start, RUN counts en cycles to completion.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pass_state_t;

endpackage

// File: rtl/tpumac.sv
// Single processing element: forwards A rightwards and B downwards one hop per
// en cycle while accumulating their signed product into a wrapping accumulator.
module tpumac #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);

  localparam int PROD_W = 2 * BITS_AB;

  logic signed [BITS_AB-1:0] a_reg;
  logic signed [BITS_AB-1:0] b_reg;
  logic signed [BITS_C-1:0]  acc_reg;
  logic signed [PROD_W-1:0]  prod;
  logic signed [BITS_C-1:0]  prod_c;

  // Full-precision signed product, then fitted to the accumulator width.
  assign prod = Ain * Bin;

  generate
    if (BITS_C > PROD_W) begin : g_prod_ext
      assign prod_c = {{(BITS_C - PROD_W){prod[PROD_W-1]}}, prod};
    end else begin : g_prod_trunc
      assign prod_c = prod[BITS_C-1:0];
    end
  endgenerate

  // Operand pipeline and accumulator; a row write overrides accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else begin
      if (en) begin
        a_reg <= Ain;
        b_reg <= Bin;
      end
      if (WrEn) begin
        acc_reg <= Cin;
      end else if (en) begin
        acc_reg <= acc_reg + prod_c;
      end
    end
  end

  assign Aout = a_reg;
  assign Bout = b_reg;
  assign Cout = acc_reg;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic array of tpumac PEs with row-addressed
// accumulator write/readout and a pass counter that flags completion.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int DIM     = DIM_DEFAULT,
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int BITS_C  = BITS_C_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic                             WrEn,
  input  logic [$clog2(DIM)-1:0]           Crow,
  input  logic [DIM-1:0][BITS_AB-1:0]      A,
  input  logic [DIM-1:0][BITS_AB-1:0]      B,
  input  logic [DIM-1:0][BITS_C-1:0]       Cin,
  output logic [DIM-1:0][BITS_C-1:0]       Cout,
  output logic                             done
);

  localparam int CROW_W = $clog2(DIM);
  localparam int CNT_W  = $clog2(3 * DIM);
  // Last en cycle of a pass: the (3*DIM-2)th one, counted from zero.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(3 * DIM - 3);

  // a_bus[r][c] / b_bus[r][c] are the operands entering PE(r,c).
  logic [BITS_AB-1:0]            a_bus [DIM][DIM];
  logic [BITS_AB-1:0]            b_bus [DIM][DIM];
  // Operands leaving the far edges are not consumed by anything.
  logic [BITS_AB-1:0]            a_spill_unused [DIM];
  logic [BITS_AB-1:0]            b_spill_unused [DIM];
  logic [DIM-1:0][BITS_C-1:0]    acc_row [DIM];
  logic [DIM-1:0]                wr_row;

  pass_state_t      state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             done_reg, done_next;

  genvar gi, gj;

  generate
    for (gi = 0; gi < DIM; gi++) begin : g_edge
      assign a_bus[gi][0] = A[gi];
      assign b_bus[0][gi] = B[gi];
      assign wr_row[gi]   = WrEn && (Crow == CROW_W'(gi));
    end

    for (gi = 0; gi < DIM; gi++) begin : g_row
      for (gj = 0; gj < DIM; gj++) begin : g_col
        logic [BITS_AB-1:0] pe_aout;
        logic [BITS_AB-1:0] pe_bout;

        tpumac #(
          .BITS_AB (BITS_AB),
          .BITS_C  (BITS_C)
        ) u_pe (
          .clk  (clk),
          .rst  (rst),
          .en   (en),
          .WrEn (wr_row[gi]),
          .Ain  (a_bus[gi][gj]),
          .Bin  (b_bus[gi][gj]),
          .Cin  (Cin[gj]),
          .Aout (pe_aout),
          .Bout (pe_bout),
          .Cout (acc_row[gi][gj])
        );

        if (gj < DIM - 1) begin : g_a_fwd
          assign a_bus[gi][gj+1] = pe_aout;
        end else begin : g_a_spill
          assign a_spill_unused[gi] = pe_aout;
        end

        if (gi < DIM - 1) begin : g_b_fwd
          assign b_bus[gi+1][gj] = pe_bout;
        end else begin : g_b_spill
          assign b_spill_unused[gj] = pe_bout;
        end
      end
    end
  endgenerate

  // Same-cycle readout of the selected accumulator row.
  assign Cout = acc_row[Crow];

  // Pass sequencer register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  // Next-state: start (re)arms the count; en cycles in RUN advance it.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          count_next = '0;
        end
      end
      RUN: begin
        if (start) begin
          count_next = '0;
        end else if (en) begin
          count_next = count_reg + 1'b1;
          if (count_reg == LAST_COUNT) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign done = done_reg;

endmodule

// File: tb/tb_systolic_array.sv
// Directed scoreboard bench for systolic_array: expected accumulator rows are
// computed by plain matrix arithmetic and queued, then popped at readout.
module tb_systolic_array;

  localparam int DIM     = 8;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int CW      = $clog2(DIM);
  localparam int PASS    = 3 * DIM - 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        en;
  logic                        start;
  logic                        WrEn;
  logic [CW-1:0]               Crow;
  logic [DIM-1:0][BITS_AB-1:0] A;
  logic [DIM-1:0][BITS_AB-1:0] B;
  logic [DIM-1:0][BITS_C-1:0]  Cin;
  logic [DIM-1:0][BITS_C-1:0]  Cout;
  logic                        done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [BITS_C-1:0] exp_q[$];
  int amat [DIM][DIM];
  int bmat [DIM][DIM];
  int done_wall;
  int done_cnt;

  always #10 clk = ~clk;

  systolic_array #(
    .DIM     (DIM),
    .BITS_AB (BITS_AB),
    .BITS_C  (BITS_C)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .WrEn  (WrEn),
    .Crow  (Crow),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Cout  (Cout),
    .done  (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pop one expected row per Crow value and compare every column.
  task automatic check_rows(input string tag);
    for (int r = 0; r < DIM; r++) begin
      Crow = CW'(r);
      #1;
      for (int c = 0; c < DIM; c++) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL %s scoreboard empty observed=%0h expected=none", tag, Cout[c]);
        end else begin
          check($sformatf("%s[%0d][%0d]", tag, r, c), 32'(Cout[c]), 32'(exp_q.pop_front()));
        end
      end
      $display("txn %s row %0d read", tag, r);
    end
    Crow = '0;
  endtask

  task automatic push_zeros();
    for (int i = 0; i < DIM * DIM; i++) exp_q.push_back('0);
  endtask

  // Reference result: ordinary matrix product, wrapped to the accumulator width.
  task automatic push_matmul();
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < DIM; k++) s += amat[r][k] * bmat[k][c];
        exp_q.push_back(BITS_C'(s));
      end
    end
  endtask

  task automatic drive_skew(input int t);
    for (int i = 0; i < DIM; i++) begin
      int k;
      k = t - i;
      A[i] = (k >= 0 && k < DIM) ? BITS_AB'(amat[i][k]) : '0;
      B[i] = (k >= 0 && k < DIM) ? BITS_AB'(bmat[k][i]) : '0;
    end
  endtask

  task automatic drive_idle();
    en = 1'b0; start = 1'b0; WrEn = 1'b0; rst = 1'b0;
    A = '0; B = '0; Cin = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed one skewed pass of n_en en cycles, optionally stalling; records
  // the wall-clock cycle of the last done and how many done pulses were seen.
  task automatic run_pass(input int stall_at, input int stall_len, input int n_en,
                          output int wall_at, output int pulses);
    int wall;
    wall = 0; wall_at = -1; pulses = 0;
    for (int t = 0; t < n_en; t++) begin
      if (t == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          en = 1'b0; A = '0; B = '0;
          tick(); wall++;
          if (done) begin pulses++; wall_at = wall; end
        end
      end
      drive_skew(t);
      en = 1'b1;
      tick(); wall++;
      if (done) begin pulses++; wall_at = wall; end
    end
    en = 1'b0; A = '0; B = '0;
    tick();
    if (done) pulses++;
  endtask

  task automatic load_identity_case();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        amat[i][j] = (i == j) ? 1 : 0;
        bmat[i][j] = i * DIM + j;
      end
  endtask

  initial begin
    drive_idle();
    Crow = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset from random state, with every other control active on the reset edge.
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < DIM; c++) begin
        A[c] = BITS_AB'($urandom); B[c] = BITS_AB'($urandom); Cin[c] = BITS_C'($urandom);
      end
      en = 1'b1; WrEn = 1'($urandom); Crow = CW'($urandom); start = (i == 2);
      tick();
    end
    rst = 1'b1; en = 1'b1; WrEn = 1'b1; start = 1'b1;
    tick();
    drive_idle();
    push_zeros();
    check_rows("reset");
    check("reset_done", 32'(done), 32'd0);

    // Identity times B through the skewed feed.
    load_identity_case();
    push_matmul();
    pulse_start();
    check("start_done", 32'(done), 32'd0);
    run_pass(-1, 0, PASS, done_wall, done_cnt);
    check("ident_done_cnt", done_cnt, 1);
    check("ident_done_cycle", done_wall, PASS);
    check_rows("ident");

    // Signed wrap on the PE(0,0) path.
    do_reset();
    A[0] = 8'h80; B[0] = 8'h80; en = 1'b1;
    tick();
    en = 1'b0; Crow = '0; #1;
    exp_q.push_back(16'h4000);
    check("wrap_once", 32'(Cout[0]), 32'(exp_q.pop_front()));
    en = 1'b1;
    tick(); tick();
    en = 1'b0; #1;
    exp_q.push_back(16'hC000);
    exp_q.push_back(16'h0000);
    check("wrap_thrice", 32'(Cout[0]), 32'(exp_q.pop_front()));
    check("wrap_neighbour", 32'(Cout[1]), 32'(exp_q.pop_front()));
    $display("txn wrap acc=%0d", $signed(Cout[0]));

    // Row write beats accumulation on the same edge; other rows untouched.
    do_reset();
    for (int r = 0; r < DIM; r++) begin
      WrEn = 1'b1; Crow = CW'(r);
      for (int c = 0; c < DIM; c++) Cin[c] = BITS_C'(r * 16 + c);
      tick();
    end
    WrEn = 1'b1; Crow = CW'(3); en = 1'b1;
    for (int c = 0; c < DIM; c++) begin
      Cin[c] = 16'h1234; A[c] = BITS_AB'(c + 1); B[c] = BITS_AB'(c + 1);
    end
    tick();
    drive_idle();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        exp_q.push_back((r == 3) ? 16'h1234 : BITS_C'(r * 16 + c + ((r == 0 && c == 0) ? 1 : 0)));
    check_rows("rowwr");

    // Stall of five cycles mid-pass shifts done by five cycles.
    do_reset();
    push_matmul();
    pulse_start();
    run_pass(10, 5, PASS, done_wall, done_cnt);
    check("stall_done_cnt", done_cnt, 1);
    check("stall_done_cycle", done_wall, PASS + 5);
    check_rows("stall");

    // Second start mid-pass restarts the count without a done pulse.
    do_reset();
    pulse_start();
    done_cnt = 0;
    en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done) done_cnt++;
    end
    en = 1'b0;
    check("restart_early_done", done_cnt, 0);
    pulse_start();
    push_matmul();
    run_pass(-1, 0, PASS, done_wall, done_cnt);
    check("restart_done_cnt", done_cnt, 1);
    check("restart_done_cycle", done_wall, PASS);
    check_rows("restart");

    // Reset at en cycle 7 of a pass: accumulators cleared, pass abandoned.
    do_reset();
    pulse_start();
    for (int t = 0; t < 7; t++) begin
      drive_skew(t);
      en = 1'b1;
      tick();
    end
    rst = 1'b1; en = 1'b1;
    tick();
    drive_idle();
    push_zeros();
    check_rows("midrst");
    check("midrst_done", 32'(done), 32'd0);
    done_cnt = 0;
    en = 1'b1;
    for (int t = 0; t < PASS + 4; t++) begin
      tick();
      if (done) done_cnt++;
    end
    en = 1'b0;
    check("midrst_idle_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
